ip_cfg_shift_seq: RTL
=====================

// Module: ip_cfg_shift_seq
// PURPOSE
//  Parametrised config-shift-register test sequencer for CMS pix28 IP blocks; successor to the single-chain test1 sequencer.
//  Drives N_CHAIN config chains in parallel through delay -> reset_not -> 2*shift_len shift-in; runs its own config_clk divider.
//  Compares returning config_out against expected bits during the second pass; keeps per-chain saturating error counts.
//  Sits between the AXI-lite register bank (controls/status) and the DUT config pads; pattern source is an external shift reg.
// PARAMETERS
//  N_CHAIN    1      number of parallel config chains
//  CNT_W      14     bit-counter width; shift_len max = 2**CNT_W-1 (10376 fits)
//  DIV_W      7      width of test_delay (config_clk half-period select)
// PORTS
//  clk            in   1               FM clock 100 MHz (S_AXI_ACLK)
//  reset_not      in   1               asynchronous, active-low reset
//  enable         in   1               block select from firmware mux
//  start          in   1               level; rising edge launches a test
//  abort          in   1               synchronous abort request
//  test_delay     in   DIV_W           config_clk half-period = test_delay+1 clk; values <2 treated as 2
//  shift_len      in   CNT_W           chain length L; test shifts 2*L bits; L=0 -> immediate DONE, no error
//  mask_reset_not in   1               1: keep reset_not_o high in RESET_NOT state
//  data_bit_i     in   N_CHAIN         next bit to shift in (from pattern source)
//  exp_bit_i      in   N_CHAIN         expected returning bit for current sample
//  config_out_i   in   N_CHAIN         DUT serial output, already synchronised
//  shift_req_o    out  1               1-clk pulse: pattern source advances one bit
//  config_clk_o   out  1               DUT config clock
//  reset_not_o    out  1               DUT reset, active low
//  config_in_o    out  N_CHAIN         DUT serial input
//  config_load_o  out  1               CONFIG_REG_MODE_SHIFT_IN / _PARALLEL_OUT
//  busy_o         out  1               high outside IDLE/DONE
//  done_o         out  1               sticky; cleared by next start edge, abort or reset
//  aborted_o      out  1               sticky; cleared by next start edge or reset
//  pass_o         out  1               done_o & all err_cnt zero
//  err_cnt_o      out  N_CHAIN*CNT_W   per-chain mismatch counts, chain k at [k*CNT_W +: CNT_W]
//  state_o        out  enum            state_t_sm_ip_cfg_shift
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; config_clk_o 0, reset_not_o 1, config_in_o 0, config_load_o PARALLEL_OUT,
//   shift_req_o 0, busy/done/aborted/pass 0, err_cnt 0, divider phase 0.
//  Divider: phase counts 0..test_delay while busy; at wrap config_clk_o toggles -> rise_evt / fall_evt (1 clk). Held 0 when idle.
//  IDLE: start rising edge (enable high) -> DELAY; clears done/aborted/err_cnt; phase=0.
//  DELAY: outputs at default; first fall_evt -> RESET_NOT.
//  RESET_NOT: config_load_o=SHIFT_IN; reset_not_o=mask_reset_not; next fall_evt -> SHIFT, reset_not_o=1, config_in_o=data_bit_i.
//  SHIFT: each fall_evt: config_in_o<=data_bit_i, bit_cnt++; shift_req_o pulses exactly 2 clk before each fall_evt
//   (1 clk req latency + 1 clk source latency), so data_bit_i is valid at fall_evt.
//   Each rise_evt with bit_cnt>L: per chain, config_out_i!=exp_bit_i -> err_cnt+1, saturating at all-ones.
//   fall_evt with bit_cnt==2L -> DONE: config_load_o=PARALLEL_OUT, config_in_o=0, no shift_req_o.
//  DONE: done_o=1 one clk later; back to IDLE next clk; done_o/pass_o/err_cnt held.
//  abort in any busy state -> ABORT (1 clk, all outputs default) -> IDLE; aborted_o=1, done_o=0; abort in IDLE ignored.
//  abort and start edge in same clk: abort wins.
//  enable low: state forced IDLE, config_clk_o 0, status held; mid-test deassert behaves as abort without setting aborted_o.
//  Control inputs are sampled at start; test_delay/shift_len changes while busy are ignored.
//  bit_cnt is CNT_W+1 bits wide; no wrap.
// STRUCTURE
//  Package cms_pix28_package: add state_t_sm_ip_cfg_shift {IDLE, DELAY, RESET_NOT, SHIFT, DONE, ABORT}_IP_CS;
//   reuse CONFIG_REG_MODE_SHIFT_IN / CONFIG_REG_MODE_PARALLEL_OUT.
//  Sub-module ip_cfg_clk_div: phase counter, config_clk, rise/fall/pre-fall(-2) event strobes.
//  Error counters: generate loop over N_CHAIN.
// TESTING
//  N_CHAIN=2, L=8, test_delay=3, loopback config_in->8-bit delay->config_out, exp=delayed data
//   -> 16 fall_evts, done_o=1, err=0, pass_o=1.
//  Same, chain1 output bit 3 of pass 2 forced inverted -> err_cnt[1]=1, err_cnt[0]=0, pass_o=0.
//  mask_reset_not=0 -> reset_not_o low for exactly 2*(test_delay+1) clk; mask_reset_not=1 -> never low.
//  abort asserted at bit 5 -> ABORT one clk, then IDLE; aborted_o=1, done_o=0; outputs default.
//  Reset asserted mid-SHIFT -> all outputs return to reset values immediately; then restart -> clean pass.
//  test_delay=0 -> period equals test_delay=2 (6 clk); L=0 -> DONE with no shift_req_o; CNT_W=4, all-mismatch L=15 -> err_cnt saturates at 15.

Source files
------------

// File: rtl/cms_pix28_package.sv
// rtl/cms_pix28_package.sv - shared pix28 config-register types and constants
package cms_pix28_package;

    localparam logic CONFIG_REG_MODE_SHIFT_IN     = 1'b1;
    localparam logic CONFIG_REG_MODE_PARALLEL_OUT = 1'b0;

    typedef enum logic [2:0] {
        IDLE_IP_CS,
        DELAY_IP_CS,
        RESET_NOT_IP_CS,
        SHIFT_IP_CS,
        DONE_IP_CS,
        ABORT_IP_CS
    } state_t_sm_ip_cfg_shift;

endpackage

// File: rtl/ip_cfg_clk_div.sv
// rtl/ip_cfg_clk_div.sv - config_clk divider with rise/fall and early pre-fall strobes
module ip_cfg_clk_div #(
    parameter int DIV_W = 7
) (
    input  logic             clk,
    input  logic             reset_not,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             config_clk,
    output logic             rise_evt,
    output logic             fall_evt,
    output logic             pre_fall_evt
);

    logic [DIV_W-1:0] phase;
    logic [DIV_W-1:0] phase_nxt;
    logic             wrap;
    logic             clk_nxt;

    // pre_fall_evt fires one clk before the cycle that sits two clk ahead of a fall,
    // so a registered request lands exactly two clk before fall_evt (div >= 2 guaranteed).
    always_comb begin
        wrap         = run && (phase == div);
        phase_nxt    = wrap ? '0 : phase + DIV_W'(1);
        clk_nxt      = config_clk ^ wrap;
        rise_evt     = wrap && !config_clk;
        fall_evt     = wrap && config_clk;
        pre_fall_evt = run && clk_nxt && (phase_nxt == div - DIV_W'(2));
    end

    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            phase      <= '0;
            config_clk <= 1'b0;
        end else if (!run) begin
            phase      <= '0;
            config_clk <= 1'b0;
        end else begin
            phase      <= phase_nxt;
            config_clk <= clk_nxt;
        end
    end

endmodule

// File: rtl/ip_cfg_shift_seq.sv
// rtl/ip_cfg_shift_seq.sv - parallel config-chain shift-in/compare test sequencer
module ip_cfg_shift_seq
    import cms_pix28_package::*;
#(
    parameter int N_CHAIN = 1,
    parameter int CNT_W   = 14,
    parameter int DIV_W   = 7
) (
    input  logic                     clk,
    input  logic                     reset_not,
    input  logic                     enable,
    input  logic                     start,
    input  logic                     abort,
    input  logic [DIV_W-1:0]         test_delay,
    input  logic [CNT_W-1:0]         shift_len,
    input  logic                     mask_reset_not,
    input  logic [N_CHAIN-1:0]       data_bit_i,
    input  logic [N_CHAIN-1:0]       exp_bit_i,
    input  logic [N_CHAIN-1:0]       config_out_i,
    output logic                     shift_req_o,
    output logic                     config_clk_o,
    output logic                     reset_not_o,
    output logic [N_CHAIN-1:0]       config_in_o,
    output logic                     config_load_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     aborted_o,
    output logic                     pass_o,
    output logic [N_CHAIN*CNT_W-1:0] err_cnt_o,
    output state_t_sm_ip_cfg_shift   state_o
);

    state_t_sm_ip_cfg_shift state;
    logic                   start_q;
    logic [DIV_W-1:0]       div_q;
    logic [CNT_W-1:0]       len_q;
    logic                   mask_q;
    logic [CNT_W:0]         bit_cnt;
    logic [CNT_W:0]         two_len;
    logic                   div_run, rise_evt, fall_evt, pre_fall_evt;
    logic                   start_edge, launch, sample_evt;

    assign start_edge = start && !start_q;
    assign launch     = enable && (state == IDLE_IP_CS) && start_edge && !abort;
    assign two_len    = {len_q, 1'b0};
    assign div_run    = enable && !abort &&
                        (state inside {DELAY_IP_CS, RESET_NOT_IP_CS, SHIFT_IP_CS});
    // Only the second pass is compared: by then the chain holds bits shifted in this test.
    assign sample_evt = enable && !abort && (state == SHIFT_IP_CS) && rise_evt &&
                        (bit_cnt > {1'b0, len_q});
    assign state_o    = state;

    ip_cfg_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk          (clk),
        .reset_not    (reset_not),
        .run          (div_run),
        .div          (div_q),
        .config_clk   (config_clk_o),
        .rise_evt     (rise_evt),
        .fall_evt     (fall_evt),
        .pre_fall_evt (pre_fall_evt)
    );

    for (genvar k = 0; k < N_CHAIN; k++) begin : g_err
        logic [CNT_W-1:0] cnt_q;
        always_ff @(posedge clk or negedge reset_not) begin
            if (!reset_not) begin
                cnt_q <= '0;
            end else if (launch) begin
                cnt_q <= '0;
            end else if (sample_evt && (config_out_i[k] != exp_bit_i[k]) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
        assign err_cnt_o[k*CNT_W +: CNT_W] = cnt_q;
    end

    always_ff @(posedge clk or negedge reset_not) begin
        if (!reset_not) begin
            state         <= IDLE_IP_CS;
            start_q       <= 1'b0;
            div_q         <= DIV_W'(2);
            len_q         <= '0;
            mask_q        <= 1'b0;
            bit_cnt       <= '0;
            shift_req_o   <= 1'b0;
            reset_not_o   <= 1'b1;
            config_in_o   <= '0;
            config_load_o <= CONFIG_REG_MODE_PARALLEL_OUT;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            aborted_o     <= 1'b0;
            pass_o        <= 1'b0;
        end else begin
            start_q     <= start;
            shift_req_o <= 1'b0;
            if (!enable) begin
                state         <= IDLE_IP_CS;
                reset_not_o   <= 1'b1;
                config_in_o   <= '0;
                config_load_o <= CONFIG_REG_MODE_PARALLEL_OUT;
                busy_o        <= 1'b0;
            end else if (abort && (state inside {DELAY_IP_CS, RESET_NOT_IP_CS, SHIFT_IP_CS})) begin
                state         <= ABORT_IP_CS;
                aborted_o     <= 1'b1;
                done_o        <= 1'b0;
                reset_not_o   <= 1'b1;
                config_in_o   <= '0;
                config_load_o <= CONFIG_REG_MODE_PARALLEL_OUT;
            end else begin
                case (state)
                    IDLE_IP_CS: if (launch) begin
                        done_o    <= 1'b0;
                        aborted_o <= 1'b0;
                        pass_o    <= 1'b0;
                        div_q     <= (test_delay < DIV_W'(2)) ? DIV_W'(2) : test_delay;
                        len_q     <= shift_len;
                        mask_q    <= mask_reset_not;
                        busy_o    <= (shift_len != '0);
                        state     <= (shift_len == '0) ? DONE_IP_CS : DELAY_IP_CS;
                    end
                    DELAY_IP_CS: if (fall_evt) begin
                        state         <= RESET_NOT_IP_CS;
                        config_load_o <= CONFIG_REG_MODE_SHIFT_IN;
                        reset_not_o   <= mask_q;
                    end
                    RESET_NOT_IP_CS: if (fall_evt) begin
                        state       <= SHIFT_IP_CS;
                        reset_not_o <= 1'b1;
                        config_in_o <= data_bit_i;
                        bit_cnt     <= (CNT_W+1)'(1);
                    end
                    SHIFT_IP_CS: begin
                        if (pre_fall_evt && (bit_cnt != two_len)) shift_req_o <= 1'b1;
                        if (fall_evt) begin
                            if (bit_cnt == two_len) begin
                                state         <= DONE_IP_CS;
                                config_load_o <= CONFIG_REG_MODE_PARALLEL_OUT;
                                config_in_o   <= '0;
                                busy_o        <= 1'b0;
                            end else begin
                                config_in_o <= data_bit_i;
                                bit_cnt     <= bit_cnt + (CNT_W+1)'(1);
                            end
                        end
                    end
                    DONE_IP_CS: begin
                        state  <= IDLE_IP_CS;
                        done_o <= 1'b1;
                        pass_o <= (err_cnt_o == '0);
                    end
                    ABORT_IP_CS: begin
                        state  <= IDLE_IP_CS;
                        busy_o <= 1'b0;
                    end
                    default: state <= IDLE_IP_CS;
                endcase
            end
        end
    end

endmodule
